// File: rtl/flash_pkg.sv
// Shared definitions for the flash sequencer: state encoding and default sizing.
// FLASH_SEQ_TIMEOUT_EN (in the sequencer) enables the optional done-timeout watchdog.
package flash_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } state_e;

    localparam int FLASH_CNT_W          = 4;
    localparam int FLASH_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/flash_watchdog.sv
// Cycle counter that flags expiry when LIMIT enabled cycles pass without a clear.
// Only instantiated when FLASH_SEQ_TIMEOUT_EN is defined.
module flash_watchdog #(
    parameter int LIMIT = 64
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
    localparam logic [CW-1:0] TOP  = CW'(LIMIT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise count enabled cycles and saturate at LIMIT.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = {CW{1'b0}};
        end else if (enable_i && (count_q != TOP)) begin
            count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    // Current enabled cycle is the LIMIT-th one since the last clear.
    assign expired_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/flash_sequencer.sv
// Blinks the display N times by driving blank through 2N timer intervals.
// Define FLASH_SEQ_TIMEOUT_EN to add a sticky timeout on a missing timer_done.
module flash_sequencer
    import flash_pkg::*;
#(
    parameter int CNT_W          = FLASH_CNT_W,
    parameter int TIMEOUT_CYCLES = FLASH_TIMEOUT_CYCLES
) (
    input  logic             CLK_50MHZ,
    input  logic             RST,
    input  logic             trigger,
    input  logic [CNT_W-1:0] flashes,
    output logic             timer_start,
    input  logic             timer_done,
    output logic             blank,
    output logic             busy,
    output logic             finished,
    output logic             error
);

    state_e           state_q, state_d;
    logic [CNT_W:0]   remaining_q, remaining_d;
    logic             timer_start_q, timer_start_d;
    logic             blank_q, blank_d;
    logic             busy_q, busy_d;
    logic             finished_q, finished_d;
    logic             done_valid_s;
    logic             wd_expired_s;

    // A done pulse seen while our own start is still high belongs to the previous interval.
    assign done_valid_s = timer_done && !timer_start_q;

`ifdef FLASH_SEQ_TIMEOUT_EN
    logic error_q, error_d;

    flash_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i    (CLK_50MHZ),
        .rst_i    (RST),
        .clear_i  (timer_start_d),
        .enable_i (state_q == WAIT_DONE),
        .expired_o(wd_expired_s)
    );

    assign error = error_q;
`else
    assign wd_expired_s = 1'b0;
    assign error        = 1'b0;
`endif

    // Next-state and output decode for the sequencer.
    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        blank_d       = blank_q;
        busy_d        = busy_q;
        timer_start_d = 1'b0;
        finished_d    = 1'b0;
`ifdef FLASH_SEQ_TIMEOUT_EN
        error_d       = error_q;
`endif
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    if (flashes == {CNT_W{1'b0}}) begin
                        finished_d = 1'b1;
                    end else begin
                        remaining_d   = {flashes, 1'b0} - {{CNT_W{1'b0}}, 1'b1};
                        blank_d       = 1'b1;
                        timer_start_d = 1'b1;
                        busy_d        = 1'b1;
                        state_d       = WAIT_DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (done_valid_s) begin
                    if (remaining_q != {(CNT_W+1){1'b0}}) begin
                        blank_d       = ~blank_q;
                        remaining_d   = remaining_q - {{CNT_W{1'b0}}, 1'b1};
                        timer_start_d = 1'b1;
                    end else begin
                        blank_d    = 1'b0;
                        finished_d = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = IDLE;
                    end
                end else if (wd_expired_s) begin
                    // Abort without a finished pulse; error stays set until reset.
                    blank_d     = 1'b0;
                    busy_d      = 1'b0;
                    remaining_d = {(CNT_W+1){1'b0}};
                    state_d     = IDLE;
`ifdef FLASH_SEQ_TIMEOUT_EN
                    error_d     = 1'b1;
`endif
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: begin
                state_d     = IDLE;
                remaining_d = {(CNT_W+1){1'b0}};
                blank_d     = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and registered outputs with synchronous reset.
    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state_q       <= IDLE;
            remaining_q   <= {(CNT_W+1){1'b0}};
            timer_start_q <= 1'b0;
            blank_q       <= 1'b0;
            busy_q        <= 1'b0;
            finished_q    <= 1'b0;
`ifdef FLASH_SEQ_TIMEOUT_EN
            error_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            timer_start_q <= timer_start_d;
            blank_q       <= blank_d;
            busy_q        <= busy_d;
            finished_q    <= finished_d;
`ifdef FLASH_SEQ_TIMEOUT_EN
            error_q       <= error_d;
`endif
        end
    end

    assign timer_start = timer_start_q;
    assign blank       = blank_q;
    assign busy        = busy_q;
    assign finished    = finished_q;

endmodule

// File: tb/tb_flash_sequencer.sv
// Directed bench for flash_sequencer: timer model answers 8 cycles after each start,
// expected blank phases are queued at trigger time and popped on every timer_start.
module tb_flash_sequencer;

    localparam int CNT_W     = 4;
    localparam int TMO       = 16;
    localparam int TIMER_LAT = 8;

    logic             clk        = 1'b0;
    logic             rst        = 1'b1;
    logic             trigger    = 1'b0;
    logic [CNT_W-1:0] flashes    = '0;
    logic             timer_done = 1'b0;
    logic             timer_start, blank, busy, finished, error_o;

    int  vectors     = 0;
    int  miscompares = 0;
    bit  exp_blank_q[$];
    int  start_cnt   = 0;
    int  fin_cnt     = 0;
    bit  prev_start  = 1'b0;
    int  tmr_cnt     = 0;
    bit  timer_en    = 1'b1;
    bit  inject      = 1'b0;
    bit  done_now;

    always #10 clk = ~clk;

    flash_sequencer #(
        .CNT_W         (CNT_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK_50MHZ  (clk),
        .RST        (rst),
        .trigger    (trigger),
        .flashes    (flashes),
        .timer_start(timer_start),
        .timer_done (timer_done),
        .blank      (blank),
        .busy       (busy),
        .finished   (finished),
        .error      (error_o)
    );

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkn(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input int n);
        for (int i = 0; i < 2 * n; i++) exp_blank_q.push_back((i % 2) == 0);
    endtask

    task automatic wait_fin(input string tag, input int maxc, output bit busy_ok);
        int n;
        n = 0;
        busy_ok = 1'b1;
        while (finished !== 1'b1 && n < maxc) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            n++;
        end
        check1({tag, "_finished"}, finished, 1'b1);
    endtask

    // Timer model and scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        done_now = inject;
        if (tmr_cnt > 0) begin
            tmr_cnt--;
            if (tmr_cnt == 0 && timer_en) done_now = 1'b1;
        end
        if (timer_start === 1'b1) begin
            tmr_cnt = TIMER_LAT;
            start_cnt++;
            check1("start_single", prev_start, 1'b0);
            check1("sb_nonempty", exp_blank_q.size() != 0, 1'b1);
            if (exp_blank_q.size() != 0) check1("blank_phase", blank, exp_blank_q.pop_front());
        end
        if (finished === 1'b1) fin_cnt++;
        prev_start = timer_start;
        timer_done = done_now;
    end

    initial begin
        int s0, s1, f0, n;
        bit ok;

        // Reset values
        tick(); tick();
        check1("rst_start", timer_start, 1'b0);
        check1("rst_blank", blank, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_finished", finished, 1'b0);
        check1("rst_error", error_o, 1'b0);
        rst = 1'b0;
        tick();

        // 1: three flashes
        s0 = start_cnt; f0 = fin_cnt;
        flashes = 4'd3; trigger = 1'b1; push_seq(3);
        tick();
        trigger = 1'b0;
        check1("t1_start", timer_start, 1'b1);
        check1("t1_blank", blank, 1'b1);
        check1("t1_busy", busy, 1'b1);
        wait_fin("t1", 200, ok);
        check1("t1_busy_held", ok, 1'b1);
        check1("t1_blank_end", blank, 1'b0);
        check1("t1_busy_end", busy, 1'b0);
        checkn("t1_starts", start_cnt - s0, 6);
        tick();
        check1("t1_fin_width", finished, 1'b0);
        checkn("t1_fin_cnt", fin_cnt - f0, 1);

        // 2: zero flashes
        s0 = start_cnt;
        flashes = 4'd0; trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check1("t2_finished", finished, 1'b1);
        check1("t2_busy", busy, 1'b0);
        check1("t2_blank", blank, 1'b0);
        check1("t2_start", timer_start, 1'b0);
        tick();
        check1("t2_fin_width", finished, 1'b0);
        checkn("t2_starts", start_cnt - s0, 0);

        // 3: count latched, held trigger ignored until the finished cycle
        s0 = start_cnt;
        flashes = 4'd2; trigger = 1'b1; push_seq(2);
        tick();
        flashes = 4'd7;
        wait_fin("t3", 200, ok);
        check1("t3_busy_held", ok, 1'b1);
        checkn("t3_starts", start_cnt - s0, 4);
        s1 = start_cnt;
        flashes = 4'd1; push_seq(1);
        tick();
        check1("t3_reaccept_busy", busy, 1'b1);
        check1("t3_reaccept_start", timer_start, 1'b1);
        trigger = 1'b0; flashes = 4'd7;
        wait_fin("t3b", 100, ok);
        checkn("t3b_starts", start_cnt - s1, 2);
        tick();

        // 4: spurious done in IDLE and in the start cycle
        inject = 1'b1;
        tick();
        inject = 1'b0;
        check1("t4_idle_busy", busy, 1'b0);
        check1("t4_idle_blank", blank, 1'b0);
        check1("t4_idle_start", timer_start, 1'b0);
        check1("t4_idle_fin", finished, 1'b0);
        s0 = start_cnt;
        flashes = 4'd1; trigger = 1'b1; push_seq(1);
        tick();
        trigger = 1'b0; inject = 1'b1;
        tick();
        inject = 1'b0;
        check1("t4_stale_blank", blank, 1'b1);
        check1("t4_stale_start", timer_start, 1'b0);
        wait_fin("t4", 100, ok);
        checkn("t4_starts", start_cnt - s0, 2);
        tick();

        // 5: reset during the third phase of four flashes
        s0 = start_cnt;
        flashes = 4'd4; trigger = 1'b1; push_seq(4);
        tick();
        trigger = 1'b0;
        n = 0;
        while (start_cnt - s0 < 3 && n < 100) begin
            tick();
            n++;
        end
        checkn("t5_third_phase", start_cnt - s0, 3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check1("t5_rst_start", timer_start, 1'b0);
        check1("t5_rst_blank", blank, 1'b0);
        check1("t5_rst_busy", busy, 1'b0);
        check1("t5_rst_fin", finished, 1'b0);
        exp_blank_q.delete();
        f0 = fin_cnt;
        repeat (12) tick();
        checkn("t5_no_fin", fin_cnt - f0, 0);
        check1("t5_idle_busy", busy, 1'b0);
        s0 = start_cnt;
        flashes = 4'd4; trigger = 1'b1; push_seq(4);
        tick();
        trigger = 1'b0;
        wait_fin("t5", 300, ok);
        check1("t5_busy_held", ok, 1'b1);
        checkn("t5_starts", start_cnt - s0, 8);
        tick();

        // 6: timer never answers
        timer_en = 1'b0;
        flashes = 4'd1; trigger = 1'b1; exp_blank_q.push_back(1'b1);
        tick();
        trigger = 1'b0;
`ifdef FLASH_SEQ_TIMEOUT_EN
        repeat (TMO - 1) tick();
        check1("t6_pre_error", error_o, 1'b0);
        check1("t6_pre_busy", busy, 1'b1);
        tick();
        check1("t6_error", error_o, 1'b1);
        check1("t6_busy", busy, 1'b0);
        check1("t6_blank", blank, 1'b0);
        check1("t6_fin", finished, 1'b0);
        repeat (5) tick();
        check1("t6_error_sticky", error_o, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check1("t6_error_cleared", error_o, 1'b0);
`else
        repeat (60) tick();
        check1("t6_error", error_o, 1'b0);
        check1("t6_busy", busy, 1'b1);
        check1("t6_blank", blank, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check1("t6_rst_busy", busy, 1'b0);
`endif
        timer_en = 1'b1;
        checkn("sb_drained", exp_blank_q.size(), 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
